// File: rtl/aes_req_sequencer.sv
// aes_req_sequencer: buffers plaintext/key requests in a small FIFO and feeds
// them to an AES core one block at a time. AES_en is held until the core
// reports valid or the timeout expires. The result is then offered on a
// valid/ready response port, followed by a short enable-low gap.
//
// Handshakes (both ports): a transfer happens on a rising AES_clk edge where
// valid and ready are both 1. The request side accepts whenever req_ready
// (= FIFO not full). The response side holds rsp_valid, rsp_data and
// rsp_timeout stable until the consumer raises rsp_ready.
module aes_req_sequencer #(
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 64,
    parameter int IDLE_GAP = 2
) (
    input  logic                       AES_clk,
    input  logic                       AES_rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [127:0]               req_data,
    input  logic [127:0]               req_key,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [127:0]               rsp_data,
    output logic                       rsp_timeout,
    output logic                       AES_en,
    output logic [127:0]               AES_data_in,
    output logic [127:0]               AES_key_in,
    input  logic [127:0]               AES_data_out,
    input  logic                       AES_data_out_valid,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [7:0]    TO_LAST    = 8'(TIMEOUT - 1);
    localparam logic [3:0]    GAP_LAST   = 4'(IDLE_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [127:0]    r_mem_data [DEPTH];
    logic [127:0]    r_mem_key  [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_count;
    logic [7:0]      r_run_cnt;
    logic [3:0]      r_gap_cnt;
    logic            r_en;
    logic [127:0]    r_data_in;
    logic [127:0]    r_key_in;
    logic            r_rsp_valid;
    logic [127:0]    r_rsp_data;
    logic            r_rsp_timeout;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    assign w_full  = (r_count == FULL_LEVEL);
    assign w_empty = (r_count == '0);
    assign w_push  = req_valid && !w_full;
    // The FIFO head leaves exactly when the FSM launches a block from IDLE.
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    assign req_ready   = !w_full;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_timeout = r_rsp_timeout;
    assign AES_en      = r_en;
    assign AES_data_in = r_data_in;
    assign AES_key_in  = r_key_in;
    assign busy        = (r_state != S_IDLE) || !w_empty;
    assign fifo_level  = r_count;

    // Request storage; contents need no reset since the level gates every read.
    always_ff @(posedge AES_clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= req_data;
            r_mem_key[r_wr_ptr]  <= req_key;
        end
    end

    // FIFO pointers and level; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge AES_clk) begin
        if (!AES_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Block sequencing FSM with registered core-side and response-side outputs.
    always_ff @(posedge AES_clk) begin
        if (!AES_rst_n) begin
            r_state       <= S_IDLE;
            r_run_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_en          <= 1'b0;
            r_data_in     <= '0;
            r_key_in      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_data_in <= r_mem_data[r_rd_ptr];
                        r_key_in  <= r_mem_key[r_rd_ptr];
                        r_en      <= 1'b1;
                        r_run_cnt <= '0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A core valid in the final timeout cycle still counts as a result.
                    if (AES_data_out_valid) begin
                        r_rsp_data    <= AES_data_out;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_en          <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (r_run_cnt == TO_LAST) begin
                        r_rsp_data    <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_en          <= 1'b0;
                        r_state       <= S_RESP;
                    end else begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_gap_cnt   <= '0;
                        r_state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_sequencer.sv
// tb_aes_req_sequencer: directed bench with an AES core stub and a
// transaction-level model of the request/response streams.
module tb_aes_req_sequencer;

    localparam int DEPTH    = 4;
    localparam int TIMEOUT  = 64;
    localparam int IDLE_GAP = 2;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
    } req_t;

    logic         AES_clk;
    logic         AES_rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_data;
    logic [127:0] req_key;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_timeout;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;
    logic         busy;
    logic [2:0]   fifo_level;

    int checks = 0;
    int errors = 0;

    aes_req_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .IDLE_GAP(IDLE_GAP)) dut (
        .AES_clk(AES_clk),
        .AES_rst_n(AES_rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data(req_data),
        .req_key(req_key),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout),
        .AES_en(AES_en),
        .AES_data_in(AES_data_in),
        .AES_key_in(AES_key_in),
        .AES_data_out(AES_data_out),
        .AES_data_out_valid(AES_data_out_valid),
        .busy(busy),
        .fifo_level(fifo_level)
    );

    // ---------------- clock ----------------
    initial begin
        AES_clk = 1'b0;
        forever #5 AES_clk = ~AES_clk;
    end

    // ---------------- core stub ----------------
    // Stand-in for AES_top: answers `lat` cycles after enable rises; the FIPS
    // vector returns its real ciphertext, anything else a fixed mixing function.
    int   lat      = 5;
    bit   suppress = 1'b0;
    bit   stray    = 1'b0;
    logic [7:0] core_cnt;

    function automatic logic [127:0] core_f(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0;
    endfunction

    always @(posedge AES_clk) core_cnt <= AES_en ? core_cnt + 8'd1 : 8'd0;

    assign AES_data_out       = core_f(AES_data_in, AES_key_in);
    assign AES_data_out_valid = (AES_en && !suppress && (int'(core_cnt) == lat - 1)) || stray;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model + scoreboard ----------------
    req_t  req_q[$];
    req_t  pend_req;
    req_t  cur;
    bit    cur_valid = 1'b0;
    bit    cur_to    = 1'b0;
    bit    rst_seen  = 1'b1;
    bit    pend_push = 1'b0;
    bit    pend_hs   = 1'b0;
    bit    prev_en   = 1'b0;
    int    gap_left  = 0;
    int    en_len    = 0;
    int    low_len   = 0;
    int    exp_len   = 0;
    int    last_high = 0;
    int    last_low  = 0;
    int    rsp_cnt   = 0;

    // Compare process: apply what happened at the last edge, then check outputs.
    always @(negedge AES_clk) begin
        if (rst_seen) begin
            req_q.delete();
            cur_valid = 1'b0;
            gap_left  = 0;
            en_len    = 0;
            low_len   = 0;
        end else begin
            if (pend_push) req_q.push_back(pend_req);
            if (pend_hs) begin
                gap_left = IDLE_GAP;
                rsp_cnt++;
            end else if (gap_left > 0) begin
                gap_left--;
            end
            if (AES_en && !prev_en) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL start_without_request actual=1 required=0 @%0t", $time);
                end else begin
                    cur = req_q.pop_front();
                    check("aes_data_in", AES_data_in, cur.pt);
                    check("aes_key_in", AES_key_in, cur.key);
                    cur_valid = 1'b1;
                    cur_to    = suppress || (lat > TIMEOUT);
                    exp_len   = cur_to ? TIMEOUT : lat;
                end
                last_low = low_len;
                low_len  = 0;
                en_len   = 0;
            end
            if (!AES_en && prev_en) begin
                check("en_high_len", 128'(en_len), 128'(exp_len));
                check("rsp_after_run", 128'(rsp_valid), 128'(1));
                last_high = en_len;
            end
            if (AES_en) en_len++;
            else        low_len++;
        end

        check("fifo_level", 128'(fifo_level), 128'(req_q.size()));
        check("req_ready", 128'(req_ready), 128'(req_q.size() < DEPTH));
        check("busy", 128'(busy),
              128'(req_q.size() != 0 || AES_en || rsp_valid || gap_left != 0));
        check("en_while_rsp", 128'(AES_en && rsp_valid), 128'(0));
        if (rsp_valid && cur_valid) begin
            check("rsp_data", rsp_data, cur_to ? 128'd0 : core_f(cur.pt, cur.key));
            check("rsp_timeout", 128'(rsp_timeout), 128'(cur_to));
        end

        rst_seen      = !AES_rst_n;
        pend_push     = AES_rst_n && req_valid && (req_q.size() < DEPTH);
        pend_req.pt   = req_data;
        pend_req.key  = req_key;
        pend_hs       = rsp_valid && rsp_ready;
        prev_en       = AES_en;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge AES_clk);
        #1;
    endtask

    task automatic push_req(input logic [127:0] pt, input logic [127:0] key);
        bit ok;
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_data  = pt;
        req_key   = key;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge AES_clk);
            ok = req_ready;
            step();
            if (ok) done = 1'b1;
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_bound actual=timeout required=accept @%0t", $time);
        end
    endtask

    // Returns at a negedge with rsp_valid high (or after the bound expires).
    task automatic wait_rsp(input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge AES_clk);
            if (rsp_valid) seen = 1'b1;
            else step();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL rsp_bound actual=none required=rsp_valid @%0t", $time);
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < max_cycles && !idle; i++) begin
            @(negedge AES_clk);
            if (!busy) idle = 1'b1;
        end
        step();
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL idle_bound actual=busy required=idle @%0t", $time);
        end
    endtask

    // ---------------- directed sequence ----------------
    int rsp_before;

    initial begin
        AES_rst_n = 1'b0;
        req_valid = 1'b0;
        req_data  = '0;
        req_key   = '0;
        rsp_ready = 1'b1;
        repeat (3) step();

        // Reset state: everything 0 except req_ready.
        check("rst_req_ready", 128'(req_ready), 128'(1));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_rsp_data", rsp_data, 128'd0);
        check("rst_aes_en", 128'(AES_en), 128'(0));
        check("rst_aes_data_in", AES_data_in, 128'd0);
        check("rst_fifo_level", 128'(fifo_level), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        AES_rst_n = 1'b1;
        step();

        // FIPS-197 vector.
        push_req(FIPS_PT, FIPS_KEY);
        wait_rsp(40);
        check("fips_data", rsp_data, FIPS_CT);
        check("fips_timeout", 128'(rsp_timeout), 128'(0));
        step();
        wait_idle(40);

        // Five back-to-back requests; the first is launched on arrival, so
        // the FIFO is full (4 waiting) once the fifth is accepted.
        rsp_before = rsp_cnt;
        for (int i = 0; i < 5; i++) begin
            push_req({4{32'h1000_0000 + 32'(i)}}, {4{32'hc0de_0000 + 32'(i * 7)}});
        end
        @(negedge AES_clk);
        check("fill_req_ready", 128'(req_ready), 128'(0));
        check("fill_level", 128'(fifo_level), 128'(4));
        step();
        wait_idle(200);
        check("fill_rsp_count", 128'(rsp_cnt - rsp_before), 128'(5));
        // Enable low: handshake cycle + IDLE_GAP gap cycles + launch cycle.
        check("fill_en_low_gap", 128'(last_low), 128'(4));

        // Backpressure with stray core valids during the response.
        rsp_ready = 1'b0;
        push_req(128'hdead_beef_0000_1111_2222_3333_4444_5555, 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100);
        push_req(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        wait_rsp(40);
        step();
        for (int i = 0; i < 20; i++) begin
            stray = (i % 3 == 0);
            step();
        end
        stray = 1'b0;
        @(negedge AES_clk);
        check("bp_rsp_valid", 128'(rsp_valid), 128'(1));
        check("bp_aes_en", 128'(AES_en), 128'(0));
        check("bp_level", 128'(fifo_level), 128'(1));
        step();
        rsp_ready = 1'b1;
        wait_idle(100);

        // Timeout: core never answers.
        suppress = 1'b1;
        push_req(128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa, FIPS_KEY);
        wait_rsp(120);
        check("to_timeout", 128'(rsp_timeout), 128'(1));
        check("to_data", rsp_data, 128'd0);
        step();
        check("to_en_len", 128'(last_high), 128'(64));
        suppress = 1'b0;
        wait_idle(40);

        // Valid in the very last timeout cycle wins.
        lat = 64;
        push_req(FIPS_PT, FIPS_KEY);
        wait_rsp(120);
        check("edge_timeout", 128'(rsp_timeout), 128'(0));
        check("edge_data", rsp_data, FIPS_CT);
        step();
        check("edge_en_len", 128'(last_high), 128'(64));
        lat = 5;
        lat = 20;
        wait_idle(40);

        // Mid-operation reset, 10 cycles into RUN, with one request queued.
        push_req(128'h7777_0000_7777_0000_7777_0000_7777_0000, FIPS_KEY);
        push_req(128'h8888_0000_8888_0000_8888_0000_8888_0000, FIPS_KEY);
        for (int i = 0; i < 40 && !AES_en; i++) step();
        repeat (9) step();
        AES_rst_n = 1'b0;
        step();
        check("mid_rst_aes_en", 128'(AES_en), 128'(0));
        check("mid_rst_level", 128'(fifo_level), 128'(0));
        check("mid_rst_rsp_valid", 128'(rsp_valid), 128'(0));
        AES_rst_n = 1'b1;
        lat = 5;
        step();
        push_req(FIPS_PT, FIPS_KEY);
        wait_rsp(40);
        check("restart_data", rsp_data, FIPS_CT);
        step();
        wait_idle(40);

        // Push and pop in the same cycle at level 3.
        rsp_ready = 1'b0;
        push_req(128'ha000, 128'hb000);
        wait_rsp(40);
        step();
        push_req(128'ha001, 128'hb001);
        push_req(128'ha002, 128'hb002);
        push_req(128'ha003, 128'hb003);
        @(negedge AES_clk);
        check("pp_level_before", 128'(fifo_level), 128'(3));
        step();
        rsp_ready = 1'b1;     // handshake on the next edge
        step();               // -> GAP
        step();               // -> GAP (second cycle)
        step();               // -> IDLE with 3 entries
        req_valid = 1'b1;
        req_data  = 128'ha004;
        req_key   = 128'hb004;
        step();               // launch pop and this push on the same edge
        req_valid = 1'b0;
        check("pp_level_after", 128'(fifo_level), 128'(3));
        wait_idle(200);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
